// File: rtl/l2_main_mem.sv
// ----------------------------------------------------------------------------
// l2_main_mem
// Line-granular main-memory model placed behind the L2 cache controller's
// memory port. One 128-bit line request (read or write) is accepted at a time
// and completed LATENCY cycles after acceptance with a one-cycle ready pulse.
// Completed reads and writes are counted for performance checks.
//
// Ports
//   clk             in   single clock, rising edge
//   rst             in   asynchronous, active-high reset
//   mem_req_addr    in   byte address of the line, bits [3:0] ignored
//   mem_req_data    in   write line data
//   mem_req_rw      in   0 = read, 1 = write
//   mem_req_valid   in   request valid
//   mem_resp_data   out  read line data, valid while mem_resp_ready = 1
//   mem_resp_ready  out  one-cycle completion pulse (reads and writes)
//   busy            out  high while a request is in flight
//   rd_count        out  completed reads since reset (wraps)
//   wr_count        out  completed writes since reset (wraps)
// ----------------------------------------------------------------------------
module l2_main_mem #(
    parameter int LINES      = 1024,
    parameter int LATENCY    = 4,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_req_addr,
    input  logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_req_rw,
    input  logic                  mem_req_valid,
    output logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  mem_resp_ready,
    output logic                  busy,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    rw_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    resp_ready_q;
    logic                    busy_q;
    logic [31:0]             rd_cnt_q;
    logic [31:0]             wr_cnt_q;

    logic                    accept;
    logic                    enter_resp;
    logic [IDX_W-1:0]        req_idx;
    logic [IDX_W-1:0]        sel_idx;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_rw;

    logic [DATA_WIDTH-1:0]   mem_q [LINES];

    // Upper address bits alias onto the same lines; low nibble is the byte offset.
    logic                    unused_addr;
    assign unused_addr = ^{mem_req_addr[31:IDX_W+4], mem_req_addr[3:0]};
    assign req_idx     = mem_req_addr[IDX_W+3:4];

    // With LATENCY = 1 the array access happens on the acceptance edge itself,
    // before the request registers are loaded, so take the live inputs then.
    assign sel_idx  = (state_q == IDLE) ? req_idx       : idx_q;
    assign sel_data = (state_q == IDLE) ? mem_req_data  : wdata_q;
    assign sel_rw   = (state_q == IDLE) ? mem_req_rw    : rw_q;

    // RESP always returns to IDLE, so a next state of RESP is always an entry.
    assign enter_resp = (state_d == RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // Leave when the decrement lands on zero so ready falls in
                // cycle T+LATENCY after the acceptance edge T.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_ready_q <= enter_resp;
            busy_q       <= (state_d != IDLE);
            if (enter_resp && !sel_rw) begin
                resp_data_q <= mem_q[sel_idx];
                rd_cnt_q    <= rd_cnt_q + 32'd1;
            end
            if (enter_resp && sel_rw) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    // Request capture; datapath only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_idx;
            wdata_q <= mem_req_data;
            rw_q    <= mem_req_rw;
        end
    end

    // Storage is never cleared; a reset before RESP discards the pending write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && sel_rw) begin
            mem_q[sel_idx] <= sel_data;
        end
    end

    assign mem_resp_data  = resp_data_q;
    assign mem_resp_ready = resp_ready_q;
    assign busy           = busy_q;
    assign rd_count       = rd_cnt_q;
    assign wr_count       = wr_cnt_q;

endmodule
